// File: rtl/pipe_ctrl_chain.sv
// rtl/pipe_ctrl_chain.sv - DEPTH-stage control-bundle pipeline with flush, load-use stall and flush exemption
// Optional bubble counter is built when PIPE_CTRL_BUBBLE_CNT_EN is defined.
module pipe_ctrl_chain #(
   parameter int                WIDTH        = 24,
   parameter int                DEPTH        = 3,
   parameter logic [WIDTH-1:0]  BUBBLE_VALUE = 24'h000001,
   parameter logic [WIDTH-1:0]  EXEMPT_MASK  = 24'hFC0000,
   parameter logic [WIDTH-1:0]  EXEMPT_VALUE = 24'h380000
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic [WIDTH-1:0]       CtrlIn,
   input  logic                   InValid,
   input  logic                   Stall,
   input  logic [DEPTH-1:0]       Flush,
   output logic [WIDTH*DEPTH-1:0] CtrlOut,
   output logic [DEPTH-1:0]       ValidOut,
   output logic [15:0]            BubbleCount
);

   logic [WIDTH-1:0] r_stage [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [WIDTH-1:0] w_next  [DEPTH];
   logic [DEPTH-1:0] w_next_valid;
   logic [DEPTH-1:0] w_bub;

   function automatic logic f_exempt(input logic [WIDTH-1:0] x);
      return (EXEMPT_MASK != '0) && ((x & EXEMPT_MASK) == EXEMPT_VALUE);
   endfunction

   // w_bub marks every stage forced to BUBBLE_VALUE by a flush or the stall bubble.
   always_comb begin
      w_bub        = '0;
      w_next_valid = r_valid;
      for (int s = 0; s < DEPTH; s++) begin
         w_next[s] = r_stage[s];
      end

      if (Flush[0] && !f_exempt(CtrlIn)) begin
         w_bub[0] = 1'b1;
      end else if (!Stall) begin
         w_next[0]       = CtrlIn;
         w_next_valid[0] = InValid;
      end

      for (int s = 1; s < DEPTH; s++) begin
         if (Flush[s] && !f_exempt(r_stage[s-1])) begin
            w_bub[s] = 1'b1;
         end else if (s == 1 && Stall) begin
            w_bub[s] = 1'b1;
         end else begin
            w_next[s]       = r_stage[s-1];
            w_next_valid[s] = r_valid[s-1];
         end
      end

      for (int s = 0; s < DEPTH; s++) begin
         if (w_bub[s]) begin
            w_next[s]       = BUBBLE_VALUE;
            w_next_valid[s] = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int s = 0; s < DEPTH; s++) begin
            r_stage[s] <= BUBBLE_VALUE;
         end
         r_valid <= '0;
      end else begin
         for (int s = 0; s < DEPTH; s++) begin
            r_stage[s] <= w_next[s];
         end
         r_valid <= w_next_valid;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_out
      assign CtrlOut[g*WIDTH +: WIDTH] = r_stage[g];
   end
   assign ValidOut = r_valid;

`ifdef PIPE_CTRL_BUBBLE_CNT_EN
   logic [15:0] r_bubble_cnt;

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         r_bubble_cnt <= '0;
      end else if (|w_bub && r_bubble_cnt != 16'hFFFF) begin
         r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
   end

   assign BubbleCount = r_bubble_cnt;
`else
   assign BubbleCount = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// tb/tb_pipe_ctrl_chain.sv - scoreboard bench for pipe_ctrl_chain (WIDTH=24, DEPTH=3)
module tb_pipe_ctrl_chain;

   localparam logic [23:0] B = 24'h000001;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic [23:0] CtrlIn = '0;
   logic        InValid = 1'b0;
   logic        Stall = 1'b0;
   logic [2:0]  Flush = '0;
   logic [71:0] CtrlOut;
   logic [2:0]  ValidOut;
   logic [15:0] BubbleCount;

   pipe_ctrl_chain dut (
      .Clk(Clk), .Rst(Rst), .CtrlIn(CtrlIn), .InValid(InValid), .Stall(Stall),
      .Flush(Flush), .CtrlOut(CtrlOut), .ValidOut(ValidOut), .BubbleCount(BubbleCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic        rst;
      logic [23:0] ctrl;
      logic        vin;
      logic        stall;
      logic [2:0]  flush;
      logic [71:0] exp_ctrl;
      logic [2:0]  exp_valid;
      logic        bub;
   } row_t;

   typedef struct {
      logic [71:0] ctrl;
      logic [2:0]  valid;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_bubbles = 0;

   function automatic logic [15:0] exp_cnt();
`ifdef PIPE_CTRL_BUBBLE_CNT_EN
      return (exp_bubbles > 65535) ? 16'hFFFF : exp_bubbles[15:0];
`else
      return 16'h0000;
`endif
   endfunction

   function automatic row_t mk(input logic rst, input logic [23:0] ctrl, input logic vin,
                               input logic stall, input logic [2:0] flush,
                               input logic [23:0] s2, input logic [23:0] s1, input logic [23:0] s0,
                               input logic [2:0] v, input logic bub);
      row_t r;
      r.rst = rst; r.ctrl = ctrl; r.vin = vin; r.stall = stall; r.flush = flush;
      r.exp_ctrl = {s2, s1, s0}; r.exp_valid = v; r.bub = bub;
      return r;
   endfunction

   task automatic apply(input row_t r);
      exp_t e;
      Rst = r.rst; CtrlIn = r.ctrl; InValid = r.vin; Stall = r.stall; Flush = r.flush;
      if (!r.rst) exp_bubbles = 0;
      else if (r.bub) exp_bubbles = exp_bubbles + 1;
      e.ctrl = r.exp_ctrl; e.valid = r.exp_valid; e.cnt = exp_cnt();
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset;
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(0, 24'hABCDEF, 1, 0, 3'b000, B, B, B, 3'b000, 0));
      rows.push_back(mk(0, 24'hABCDEF, 1, 0, 3'b000, B, B, B, 3'b000, 0));
      rows.push_back(mk(1, 24'hABCDEF, 1, 0, 3'b000, B, B, 24'hABCDEF, 3'b001, 0));
      rows.push_back(mk(1, B, 0, 0, 3'b000, B, 24'hABCDEF, B, 3'b010, 0));
      rows.push_back(mk(1, B, 0, 0, 3'b000, 24'hABCDEF, B, B, 3'b100, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = exp_q.pop_front();
         n_checks++; if (CtrlOut !== e.ctrl) begin n_fail++; $display("FAIL reset[%0d] CtrlOut got %h want %h", i, CtrlOut, e.ctrl); end
         n_checks++; if (ValidOut !== e.valid) begin n_fail++; $display("FAIL reset[%0d] ValidOut got %b want %b", i, ValidOut, e.valid); end
         n_checks++; if (BubbleCount !== e.cnt) begin n_fail++; $display("FAIL reset[%0d] BubbleCount got %h want %h", i, BubbleCount, e.cnt); end
      end
   endtask

   task automatic test_stream;
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(1, 24'h000010, 1, 0, 3'b000, B, B, 24'h10, 3'b001, 0));
      rows.push_back(mk(1, 24'h000020, 1, 0, 3'b000, B, 24'h10, 24'h20, 3'b011, 0));
      rows.push_back(mk(1, 24'h000030, 1, 0, 3'b000, 24'h10, 24'h20, 24'h30, 3'b111, 0));
      rows.push_back(mk(1, 24'h000040, 1, 0, 3'b000, 24'h20, 24'h30, 24'h40, 3'b111, 0));
      rows.push_back(mk(1, 24'h000050, 1, 0, 3'b000, 24'h30, 24'h40, 24'h50, 3'b111, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = exp_q.pop_front();
         n_checks++; if (CtrlOut !== e.ctrl) begin n_fail++; $display("FAIL stream[%0d] CtrlOut got %h want %h", i, CtrlOut, e.ctrl); end
         n_checks++; if (ValidOut !== e.valid) begin n_fail++; $display("FAIL stream[%0d] ValidOut got %b want %b", i, ValidOut, e.valid); end
         n_checks++; if (BubbleCount !== e.cnt) begin n_fail++; $display("FAIL stream[%0d] BubbleCount got %h want %h", i, BubbleCount, e.cnt); end
      end
   endtask

   task automatic test_stall;
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(1, 24'h000020, 1, 0, 3'b000, 24'h40, 24'h50, 24'h20, 3'b111, 0));
      rows.push_back(mk(1, 24'h000030, 1, 1, 3'b000, 24'h50, B, 24'h20, 3'b101, 1));
      rows.push_back(mk(1, 24'h000030, 1, 0, 3'b000, B, 24'h20, 24'h30, 3'b011, 0));
      rows.push_back(mk(1, 24'h000040, 1, 0, 3'b000, 24'h20, 24'h30, 24'h40, 3'b111, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = exp_q.pop_front();
         n_checks++; if (CtrlOut !== e.ctrl) begin n_fail++; $display("FAIL stall[%0d] CtrlOut got %h want %h", i, CtrlOut, e.ctrl); end
         n_checks++; if (ValidOut !== e.valid) begin n_fail++; $display("FAIL stall[%0d] ValidOut got %b want %b", i, ValidOut, e.valid); end
         n_checks++; if (BubbleCount !== e.cnt) begin n_fail++; $display("FAIL stall[%0d] BubbleCount got %h want %h", i, BubbleCount, e.cnt); end
      end
   endtask

   task automatic test_flush_exempt;
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(1, 24'h040010, 1, 0, 3'b001, 24'h30, 24'h40, B, 3'b110, 1));
      rows.push_back(mk(1, 24'h380010, 1, 0, 3'b001, 24'h40, B, 24'h380010, 3'b101, 0));
      rows.push_back(mk(1, 24'h000060, 1, 0, 3'b010, B, 24'h380010, 24'h60, 3'b011, 0));
      rows.push_back(mk(1, 24'h000070, 1, 0, 3'b100, 24'h380010, 24'h60, 24'h70, 3'b111, 0));
      rows.push_back(mk(1, 24'h000080, 1, 0, 3'b100, B, 24'h70, 24'h80, 3'b011, 1));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = exp_q.pop_front();
         n_checks++; if (CtrlOut !== e.ctrl) begin n_fail++; $display("FAIL flush_exempt[%0d] CtrlOut got %h want %h", i, CtrlOut, e.ctrl); end
         n_checks++; if (ValidOut !== e.valid) begin n_fail++; $display("FAIL flush_exempt[%0d] ValidOut got %b want %b", i, ValidOut, e.valid); end
         n_checks++; if (BubbleCount !== e.cnt) begin n_fail++; $display("FAIL flush_exempt[%0d] BubbleCount got %h want %h", i, BubbleCount, e.cnt); end
      end
   endtask

   task automatic test_flush_beats_stall;
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(1, 24'h000050, 1, 0, 3'b000, 24'h70, 24'h80, 24'h50, 3'b111, 0));
      rows.push_back(mk(1, 24'h000090, 1, 1, 3'b001, 24'h80, B, B, 3'b100, 1));
      rows.push_back(mk(1, 24'h0000A0, 1, 0, 3'b111, B, B, B, 3'b000, 1));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = exp_q.pop_front();
         n_checks++; if (CtrlOut !== e.ctrl) begin n_fail++; $display("FAIL flush_stall[%0d] CtrlOut got %h want %h", i, CtrlOut, e.ctrl); end
         n_checks++; if (ValidOut !== e.valid) begin n_fail++; $display("FAIL flush_stall[%0d] ValidOut got %b want %b", i, ValidOut, e.valid); end
         n_checks++; if (BubbleCount !== e.cnt) begin n_fail++; $display("FAIL flush_stall[%0d] BubbleCount got %h want %h", i, BubbleCount, e.cnt); end
      end
   endtask

   task automatic test_bubble_count;
`ifdef PIPE_CTRL_BUBBLE_CNT_EN
      Rst = 1; CtrlIn = 24'h000010; InValid = 1; Stall = 0; Flush = 3'b100;
      for (int i = 0; i < 65540; i++) begin
         @(posedge Clk);
         #1;
         exp_bubbles = exp_bubbles + 1;
      end
      n_checks++; if (BubbleCount !== exp_cnt()) begin n_fail++; $display("FAIL saturate BubbleCount got %h want %h", BubbleCount, exp_cnt()); end
      n_checks++; if (CtrlOut !== {B, 24'h10, 24'h10} || ValidOut !== 3'b011) begin n_fail++; $display("FAIL saturate pipe got %h/%b want %h/%b", CtrlOut, ValidOut, {B, 24'h10, 24'h10}, 3'b011); end
      @(posedge Clk);
      #1;
      n_checks++; if (BubbleCount !== 16'hFFFF) begin n_fail++; $display("FAIL saturate_hold BubbleCount got %h want %h", BubbleCount, 16'hFFFF); end
`else
      exp_t e;
      apply(mk(1, 24'h000010, 1, 0, 3'b100, B, B, 24'h10, 3'b001, 1));
      e = exp_q.pop_front();
      n_checks++; if (BubbleCount !== e.cnt) begin n_fail++; $display("FAIL count_off BubbleCount got %h want %h", BubbleCount, e.cnt); end
      n_checks++; if (CtrlOut !== e.ctrl) begin n_fail++; $display("FAIL count_off CtrlOut got %h want %h", CtrlOut, e.ctrl); end
`endif
   endtask

   task automatic test_reset_override;
      row_t rows[$];
      exp_t e;
      rows.push_back(mk(0, 24'hABCDEF, 1, 1, 3'b010, B, B, B, 3'b000, 0));
      rows.push_back(mk(1, 24'h000011, 1, 1, 3'b000, B, B, B, 3'b000, 1));
      rows.push_back(mk(1, 24'h000011, 1, 0, 3'b000, B, B, 24'h11, 3'b001, 0));
      foreach (rows[i]) begin
         apply(rows[i]);
         e = exp_q.pop_front();
         n_checks++; if (CtrlOut !== e.ctrl) begin n_fail++; $display("FAIL reset_override[%0d] CtrlOut got %h want %h", i, CtrlOut, e.ctrl); end
         n_checks++; if (ValidOut !== e.valid) begin n_fail++; $display("FAIL reset_override[%0d] ValidOut got %b want %b", i, ValidOut, e.valid); end
         n_checks++; if (BubbleCount !== e.cnt) begin n_fail++; $display("FAIL reset_override[%0d] BubbleCount got %h want %h", i, BubbleCount, e.cnt); end
      end
   endtask

   initial begin
      @(posedge Clk);
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_flush_exempt();
      test_flush_beats_stall();
      test_bubble_count();
      test_reset_override();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
